// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain
//   Configurable register chain (0..8 stages) for DSP operand and sideband paths.
//   Every stage carries a valid bit next to its data. The chain supports a flush,
//   an in-flight counter and, optionally, data stages that load only on valid.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   enable     clock enable; 0 holds every stage and the counter
//   flush      clears all in-flight valid bits; data still shifts if enable = 1
//   data_in    stage-0 data
//   valid_in   stage-0 qualifier
//   data_out   last-stage data (data_in when DEPTH = 0)
//   valid_out  last-stage valid (valid_in when DEPTH = 0)
//   inflight   number of set valid bits in the chain
//   busy       inflight != 0
module pipe_reg_chain #(
   parameter int unsigned      WIDTH         = 18,
   parameter int unsigned      DEPTH         = 1,
   parameter logic [WIDTH-1:0] RST_VAL       = '0,
   parameter bit               DATA_ON_VALID = 1'b0,
   localparam int unsigned     CNT_W         = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             flush,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic [CNT_W-1:0] inflight,
   output logic             busy
);

   if (DEPTH == 0) begin : g_bypass
      // Control inputs are meaningless in the combinational bypass.
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, enable, flush};

      assign data_out  = data_in;
      assign valid_out = valid_in;
      assign inflight  = '0;
      assign busy      = 1'b0;
   end else begin : g_chain
      logic [WIDTH-1:0] data_q    [DEPTH];
      logic [WIDTH-1:0] data_d    [DEPTH];
      logic [WIDTH-1:0] data_prev [DEPTH];  // data feeding stage k
      logic [DEPTH-1:0] valid_q, valid_d;
      logic [DEPTH:0]   valid_ext;          // valid_ext[k] = valid feeding stage k
      logic [CNT_W-1:0] cnt_q, cnt_d;

      assign valid_ext = {valid_q, valid_in};

      always_comb begin
         data_prev[0] = data_in;
         for (int k = 1; k < int'(DEPTH); k++) begin
            data_prev[k] = data_q[k-1];
         end
      end

      always_comb begin
         data_d  = data_q;
         valid_d = valid_q;
         cnt_d   = cnt_q;
         if (enable) begin
            // Data shifts under the load rule using the pre-flush valid bits.
            for (int k = 0; k < int'(DEPTH); k++) begin
               if (!DATA_ON_VALID || valid_ext[k]) begin
                  data_d[k] = data_prev[k];
               end
            end
            valid_d = valid_ext[DEPTH-1:0];
            cnt_d   = cnt_q + CNT_W'(valid_in) - CNT_W'(valid_q[DEPTH-1]);
         end
         if (flush) begin
            valid_d = '0;
            cnt_d   = '0;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
               data_q[k] <= RST_VAL;
            end
            valid_q <= '0;
            cnt_q   <= '0;
         end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
         end
      end

      assign data_out  = data_q[DEPTH-1];
      assign valid_out = valid_q[DEPTH-1];
      assign inflight  = cnt_q;
      assign busy      = (cnt_q != '0);

      a_cnt_matches_valid : assert property (@(posedge clk) disable iff (rst)
         cnt_q == CNT_W'($countones(valid_q)));
   end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: several instances share one stimulus stream; each
// phase checks one instance against a queue-based reference model.
module tb_pipe_reg_chain;

   localparam logic [17:0] RV = 18'h00ABC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        flush = 1'b0;
   logic        valid_in = 1'b0;
   logic [17:0] data_in = '0;

   logic [17:0] o3_data, o4_data, o2_data, o0_data, o8_data;
   logic        o3_valid, o4_valid, o2_valid, o0_valid, o8_valid;
   logic        o3_busy, o4_busy, o2_busy, o0_busy, o8_busy;
   logic [1:0]  o3_inf, o2_inf;
   logic [2:0]  o4_inf;
   logic [0:0]  o0_inf;
   logic [3:0]  o8_inf;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_reg_chain #(.WIDTH(18), .DEPTH(3), .RST_VAL(RV), .DATA_ON_VALID(1'b0)) u_d3 (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush), .data_in(data_in),
      .valid_in(valid_in), .data_out(o3_data), .valid_out(o3_valid), .inflight(o3_inf),
      .busy(o3_busy));
   pipe_reg_chain #(.WIDTH(18), .DEPTH(4), .RST_VAL(RV), .DATA_ON_VALID(1'b0)) u_d4 (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush), .data_in(data_in),
      .valid_in(valid_in), .data_out(o4_data), .valid_out(o4_valid), .inflight(o4_inf),
      .busy(o4_busy));
   pipe_reg_chain #(.WIDTH(18), .DEPTH(2), .RST_VAL(RV), .DATA_ON_VALID(1'b1)) u_d2v (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush), .data_in(data_in),
      .valid_in(valid_in), .data_out(o2_data), .valid_out(o2_valid), .inflight(o2_inf),
      .busy(o2_busy));
   pipe_reg_chain #(.WIDTH(18), .DEPTH(0), .RST_VAL(RV), .DATA_ON_VALID(1'b0)) u_d0 (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush), .data_in(data_in),
      .valid_in(valid_in), .data_out(o0_data), .valid_out(o0_valid), .inflight(o0_inf),
      .busy(o0_busy));
   pipe_reg_chain #(.WIDTH(18), .DEPTH(8), .RST_VAL(RV), .DATA_ON_VALID(1'b0)) u_d8 (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush), .data_in(data_in),
      .valid_in(valid_in), .data_out(o8_data), .valid_out(o8_valid), .inflight(o8_inf),
      .busy(o8_busy));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: data history of every enabled edge (newest first) and the
   // ages, in enabled edges, of the valid samples still inside the chain.
   int unsigned m_depth = 1;
   logic [17:0] m_hist[$];
   int          m_ages[$];

   task automatic model_edge(input logic r, input logic f, input logic e, input logic v,
                             input logic [17:0] d);
      if (r) begin
         m_hist.delete();
         for (int i = 0; i < int'(m_depth); i++) m_hist.push_back(RV);
         m_ages.delete();
      end else begin
         if (e) begin
            m_hist.push_front(d);
            void'(m_hist.pop_back());
         end
         if (f) begin
            m_ages.delete();
         end else if (e) begin
            foreach (m_ages[i]) m_ages[i]++;
            while (m_ages.size() > 0 && m_ages[0] > int'(m_depth)) void'(m_ages.pop_front());
            if (v) m_ages.push_back(1);
         end
      end
   endtask

   task automatic step(input logic r, input logic f, input logic e, input logic v,
                       input logic [17:0] d);
      rst = r; flush = f; enable = e; valid_in = v; data_in = d;
      @(posedge clk);
      #1;
      model_edge(r, f, e, v, d);
   endtask

   task automatic check_chain(input string tag, input logic [17:0] dout, input logic vout,
                              input logic [63:0] inf, input logic bsy);
      logic ev;
      ev = (m_ages.size() > 0) && (m_ages[0] == int'(m_depth));
      check({tag, ".data"},  64'(dout), 64'(m_hist[m_depth-1]));
      check({tag, ".valid"}, 64'(vout), 64'(ev));
      check({tag, ".infl"},  inf, 64'(m_ages.size()));
      check({tag, ".busy"},  64'(bsy), 64'(m_ages.size() != 0));
   endtask

   task automatic chk3(input string tag);
      check_chain(tag, o3_data, o3_valid, 64'(o3_inf), o3_busy);
   endtask
   task automatic chk4(input string tag);
      check_chain(tag, o4_data, o4_valid, 64'(o4_inf), o4_busy);
   endtask
   task automatic chk8(input string tag);
      check_chain(tag, o8_data, o8_valid, 64'(o8_inf), o8_busy);
   endtask

   initial begin
      logic [17:0] vals [3];
      logic r, f, e, v;

      // DEPTH=3 streaming: three back-to-back samples, then drain.
      m_depth = 3;
      step(1'b1, 1'b0, 1'b1, 1'b0, 18'h0);
      chk3("a_rst");
      check("a_rst_data", 64'(o3_data), 64'(RV));
      step(1'b0, 1'b0, 1'b1, 1'b1, 18'h00011); chk3("a_e1");
      step(1'b0, 1'b0, 1'b1, 1'b1, 18'h00022); chk3("a_e2");
      step(1'b0, 1'b0, 1'b1, 1'b1, 18'h00033); chk3("a_e3");
      check("a_first_out", 64'(o3_data), 64'h11);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 18'($urandom));
         chk3("a_drain");
      end

      // DEPTH=3 with enable held low mid-flight.
      step(1'b1, 1'b0, 1'b1, 1'b0, 18'h0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 18'h2AAAA); chk3("b_e1");
      step(1'b0, 1'b0, 1'b1, 1'b0, 18'h0);     chk3("b_e2");
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'($urandom), 18'($urandom));
         chk3("b_hold");
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, 18'h0);
      chk3("b_e3");
      check("b_exit_valid", 64'(o3_valid), 64'h1);
      check("b_exit_data", 64'(o3_data), 64'h2AAAA);

      // DEPTH=4: fill, then flush with a valid input; then fill and reset.
      m_depth = 4;
      step(1'b1, 1'b0, 1'b1, 1'b0, 18'h0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1, 18'($urandom));
         chk4("c_fill");
      end
      check("c_full", 64'(o4_inf), 64'd4);
      step(1'b0, 1'b0, 1'b1, 1'b1, 18'($urandom)); chk4("c_full_stream");
      step(1'b0, 1'b1, 1'b1, 1'b1, 18'($urandom)); chk4("c_flush");
      check("c_flush_infl", 64'(o4_inf), 64'd0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 18'($urandom));
      step(1'b1, 1'b0, 1'b1, 1'b1, 18'($urandom)); chk4("c_rst_full");
      check("c_rst_data", 64'(o4_data), 64'(RV));

      // DEPTH=2 data-on-valid: invalid data must not propagate.
      step(1'b1, 1'b0, 1'b1, 1'b0, 18'h0);
      check("d_rst_data", 64'(o2_data), 64'(RV));
      step(1'b0, 1'b0, 1'b1, 1'b1, 18'h00005);
      check("d_e1_inf", 64'(o2_inf), 64'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 18'h3FFFF);
      check("d_e2_data", 64'(o2_data), 64'h5);
      check("d_e2_valid", 64'(o2_valid), 64'h1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 18'h12345);
      check("d_e3_data", 64'(o2_data), 64'h5);
      check("d_e3_valid", 64'(o2_valid), 64'h0);
      check("d_e3_inf", 64'(o2_inf), 64'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 18'h3FFFF);
      check("d_e4_data", 64'(o2_data), 64'h5);

      // DEPTH=0 bypass under rst and flush.
      vals[0] = 18'h00000; vals[1] = 18'h3FFFF; vals[2] = 18'h15555;
      rst = 1'b1; flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data_in = vals[i]; valid_in = 1'(i); enable = 1'($urandom);
         #1;
         check("e_data", 64'(o0_data), 64'(vals[i]));
         check("e_valid", 64'(o0_valid), 64'(i % 2));
         @(posedge clk); #1;
         check("e_data_edge", 64'(o0_data), 64'(vals[i]));
         check("e_infl", 64'(o0_inf), 64'd0);
         check("e_busy", 64'(o0_busy), 64'd0);
      end

      // DEPTH=8 randomised run.
      m_depth = 8;
      step(1'b1, 1'b0, 1'b1, 1'b0, 18'h0);
      chk8("f_rst");
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(99) == 0);
         f = ($urandom_range(19) == 0);
         e = ($urandom_range(3) != 0);
         v = ($urandom_range(9) < 6);
         step(r, f, e, v, 18'($urandom));
         chk8("f_rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
